// File: rtl/uart_tx_mmio_if.sv
// Core data-memory port as seen by the memory-mapped UART transmitter.
// The core drives the master side; the UART register block is the slave.
interface uart_tx_mmio_if;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  mem_ctrl;
    logic [31:0] write_data;
    logic        sel;
    logic [31:0] read_data;

    modport master (
        output addr, we, mem_ctrl, write_data,
        input  sel, read_data
    );

    modport slave (
        input  addr, we, mem_ctrl, write_data,
        output sel, read_data
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TX FIFO fed by core stores, drained by a bit-serial FSM.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit); default build sends 8N1.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_mmio_if.slave bus,
    output logic          tx
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    localparam logic PAR_EN = 1'b0;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state, state_n;
    logic [15:0] baud_div, baud_cnt, baud_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shift, shift_n;
    logic        tx_n;
    logic        ovf;
    logic [PW:0] wr_ptr, rd_ptr;
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [7:0]  head;
    logic        full, empty, busy;
    logic        wr_en, push_req, push, pop;
    logic [1:0]  offset;
    logic [31:0] rdata;
    logic        unused_bits;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_n;
`endif

    assign bus.sel  = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign offset   = bus.addr[3:2];
    assign wr_en    = bus.sel & bus.we;
    assign push_req = wr_en && (offset == 2'd0);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    // A full FIFO still accepts a byte when the FSM frees a slot in the same cycle
    assign push     = push_req && (!full || pop);
    assign head     = fifo_mem[rd_ptr[PW-1:0]];
    assign busy     = (state != IDLE);
    assign unused_bits = ^{bus.addr[1:0], bus.write_data[31:16]};

    always_comb begin
        rdata = 32'h0;
        if (bus.sel) begin
            case (offset)
                2'd1:    rdata = {27'h0, PAR_EN, ovf, busy, empty, full};
                2'd2:    rdata = {16'h0, baud_div};
                default: rdata = 32'h0;
            endcase
        end
    end
    assign bus.read_data = rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_div <= DEFAULT_DIV;
            ovf      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (wr_en && offset == 2'd2 && bus.mem_ctrl == 2'b10)
                baud_div <= bus.write_data[15:0];
            if (push_req && full && !pop)
                ovf <= 1'b1;
            else if (wr_en && offset == 2'd1 && bus.write_data[3])
                ovf <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PW-1:0]] <= bus.write_data[7:0];
        shift <= shift_n;
`ifdef UART_TX_PARITY_EN
        par_q <= par_n;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= 16'h0;
            bit_cnt  <= 3'h0;
        end else begin
            state    <= state_n;
            tx       <= tx_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
        end
    end

    // Every state entry reloads the baud counter, so a new BAUD_DIV only affects the next bit
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    state_n = START;
                    baud_n  = baud_div;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^head;
`endif
                end
            end
            START: begin
                if (baud_cnt == 16'h0) begin
                    state_n = DATA;
                    baud_n  = baud_div;
                    bit_n   = 3'h0;
                end else begin
                    baud_n = baud_cnt - 16'h1;
                end
            end
            DATA: begin
                if (baud_cnt == 16'h0) begin
                    baud_n = baud_div;
                    if (bit_cnt == 3'h7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n   = bit_cnt + 3'h1;
                        shift_n = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_n = baud_cnt - 16'h1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_cnt == 16'h0) begin
                    state_n = STOP;
                    baud_n  = baud_div;
                end else begin
                    baud_n = baud_cnt - 16'h1;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == 16'h0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = START;
                        baud_n  = baud_div;
`ifdef UART_TX_PARITY_EN
                        par_n   = ^head;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt - 16'h1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx is computed from the next state so the pin itself comes straight from a flop
    always_comb begin
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end
endmodule
